reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL provide parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 5: address width; depth = 2**ADDR_W entries.
REQ-003 SHALL provide parameter NUM_RD, default 2: number of read ports, legal range 1..4.
REQ-004 SHALL provide port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL provide port reset, input, 1: asynchronous, active-low reset; asserted at 0.
REQ-006 SHALL provide ports we0 / wa0 / wd0, inputs, 1 / ADDR_W / DATA_W: write port 0, the ALU writeback.
REQ-007 SHALL provide ports we1 / wa1 / wd1, inputs, 1 / ADDR_W / DATA_W: write port 1, the load writeback; it also clears the busy bit.
REQ-008 SHALL provide port rd_addr, input, NUM_RD*ADDR_W: packed read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-009 SHALL provide port rd_data, output, NUM_RD*DATA_W: packed read data, same packing as rd_addr.
REQ-010 SHALL provide port rd_busy, output, NUM_RD: per-port flag meaning the addressed register has a pending load.
REQ-011 SHALL provide ports sb_set / sb_addr, inputs, 1 / ADDR_W: marks a destination busy when a load issues.
REQ-012 SHALL provide port pending_cnt, output, ADDR_W+1: number of busy registers.

Function
REQ-013 Entry 0 SHALL read as 0, SHALL ignore writes, and SHALL never be busy.
REQ-014 Each read port SHALL be combinational: rd_data = entry[rd_addr] and rd_busy = busy[rd_addr], subject to the configuration in REQ-026..027.
REQ-015 On a clock edge, weN=1 with waN!=0 SHALL update entry[waN] with wdN.
REQ-016 If we0 and we1 both target the same nonzero address, port 1 SHALL win.
REQ-017 sb_set=1 with sb_addr!=0 SHALL set busy[sb_addr] on the clock edge.
REQ-018 we1=1 with wa1!=0 SHALL clear busy[wa1] on the clock edge; writes on port 0 SHALL NOT affect busy.
REQ-019 If sb_set and a port-1 clear target the same address in one cycle, the set SHALL win and busy SHALL stay 1.
REQ-020 pending_cnt SHALL be a registered count equal at all times to the population count of busy[].
- Increments by 1 on a 0->1 busy transition; decrements by 1 on a 1->0 transition.
- Both in one cycle on different addresses: count unchanged.
- Setting an already-busy register or clearing an idle register: no count change.
REQ-021 pending_cnt SHALL saturate neither up nor down; its range 0..2**ADDR_W-1 is guaranteed by REQ-013.
REQ-022 Write latency SHALL be 1 cycle: a write is visible through the array on the cycle after the edge.

Reset
REQ-023 While reset=0, all entries SHALL be 0, all busy bits SHALL be 0, and pending_cnt SHALL be 0, regardless of clk.
REQ-024 Reset asserted mid-operation SHALL discard any same-cycle write or sb_set.
REQ-025 After reset deasserts, the first rising edge SHALL perform normal updates.

Configuration
REQ-026 With RF_BYPASS_EN defined, each read port SHALL forward same-cycle write data combinationally.
- Priority: port 1, then port 0, then the array.
- Address 0 is never forwarded.
- rd_busy SHALL read 0 when we1 clears the addressed register in the same cycle and sb_set does not target it.
REQ-027 With RF_BYPASS_EN undefined, reads SHALL return registered array and busy state only; there is no forwarding path.

Verification
REQ-028 Reset and zero register: reset=0, then write wa0=0, wd0=32'hFFFFFFFF -> every rd_data reads 0 and pending_cnt=0.
REQ-029 Write collision: we0=we1=1, wa0=wa1=5, wd0=32'h11, wd1=32'h22 -> next cycle entry 5 reads 32'h22.
REQ-030 Scoreboard collision: sb_set on 7, then same-cycle sb_set 7 and we1 wa1=7 -> busy[7]=1 and pending_cnt=1; a later we1 wa1=7 -> busy 0 and pending_cnt=0.
REQ-031 Bypass: with RF_BYPASS_EN, we1 wa1=3 wd1=32'hABCD and rd_addr port0=3 in the same cycle -> rd_data0=32'hABCD and rd_busy0=0 in that cycle; without the macro, the old value is returned.
REQ-032 Count stress: sb_set registers 1..31 on successive cycles -> pending_cnt=31; clear all 31 in random order -> pending_cnt=0.
REQ-033 Reset mid-load: busy[9]=1, assert reset concurrently with we1 wa1=9 -> busy all 0, entry 9 reads 0, pending_cnt=0.

Source files
------------

// File: rtl/reg_file_sb.sv
// Register file with load scoreboard: two write ports, NUM_RD combinational read ports,
// per-entry busy bits and a registered pending count. Define RF_BYPASS_EN for same-cycle write forwarding.
module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          wa0,
  input  logic [DATA_W-1:0]          wd0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          wa1,
  input  logic [DATA_W-1:0]          wd1,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       sb_set,
  input  logic [ADDR_W-1:0]          sb_addr,
  output logic [ADDR_W:0]            pending_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic wr0_ok, wr1_ok, set_ok;
  logic set_rise, clr_fall;

  assign wr0_ok = we0 && (wa0 != '0);
  assign wr1_ok = we1 && (wa1 != '0);
  assign set_ok = sb_set && (sb_addr != '0);

  // Port 1 is applied last so it wins a same-address collision.
  always_comb begin
    mem_d = mem_q;
    if (wr0_ok) mem_d[wa0] = wd0;
    if (wr1_ok) mem_d[wa1] = wd1;
    mem_d[0] = '0;
  end

  // Set is applied after clear so an issuing load keeps its destination busy.
  always_comb begin
    busy_d = busy_q;
    if (wr1_ok) busy_d[wa1] = 1'b0;
    if (set_ok) busy_d[sb_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  assign set_rise = set_ok && !busy_q[sb_addr];
  assign clr_fall = wr1_ok && busy_q[wa1] && !(set_ok && (sb_addr == wa1));

  always_comb begin
    cnt_d = cnt_q + (ADDR_W+1)'(set_rise) - (ADDR_W+1)'(clr_fall);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pending_cnt = cnt_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
    logic fwd1, fwd0, set_here;
    assign fwd1     = wr1_ok && (wa1 == ra);
    assign fwd0     = wr0_ok && (wa0 == ra);
    assign set_here = set_ok && (sb_addr == ra);
    assign rd_data[k*DATA_W +: DATA_W] = fwd1 ? wd1 : (fwd0 ? wd0 : mem_q[ra]);
    assign rd_busy[k] = busy_q[ra] && !(fwd1 && !set_here);
`else
    assign rd_data[k*DATA_W +: DATA_W] = mem_q[ra];
    assign rd_busy[k] = busy_q[ra];
`endif
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: vector table, hand sequences for reset/bypass/count corners,
// then randomized traffic against an array-based reference model.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we0 = 1'b0, we1 = 1'b0, sb_set = 1'b0;
  logic [4:0]  wa0 = '0, wa1 = '0, sb_addr = '0;
  logic [31:0] wd0 = '0, wd1 = '0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [5:0]  pending_cnt;

  reg_file_sb dut (
    .clk(clk), .reset(reset),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_mem [32];
  logic        ref_busy [32];

  typedef struct {
    logic we0; logic [4:0] wa0; logic [31:0] wd0;
    logic we1; logic [4:0] wa1; logic [31:0] wd1;
    logic sb;  logic [4:0] sba;
    logic [4:0] chk; logic [31:0] exp_d; logic exp_b; int exp_c;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    we0 = 1'b0; we1 = 1'b0; sb_set = 1'b0;
    wa0 = '0; wa1 = '0; sb_addr = '0; wd0 = '0; wd1 = '0;
  endtask

  function automatic int ref_popcount();
    int c = 0;
    for (int i = 0; i < 32; i++) if (ref_busy[i]) c++;
    return c;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
`ifdef RF_BYPASS_EN
    if (we1 && wa1 == a) return wd1;
    if (we0 && wa0 == a) return wd0;
`endif
    return ref_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
    if (we1 && wa1 == a && !(sb_set && sb_addr == a)) return 1'b0;
`endif
    return ref_busy[a];
  endfunction

  task automatic ref_clear();
    for (int i = 0; i < 32; i++) begin ref_mem[i] = '0; ref_busy[i] = 1'b0; end
  endtask

  task automatic ref_step();
    if (we0 && wa0 != 0) ref_mem[wa0] = wd0;
    if (we1 && wa1 != 0) ref_mem[wa1] = wd1;
    if (we1 && wa1 != 0) ref_busy[wa1] = 1'b0;
    if (sb_set && sb_addr != 0) ref_busy[sb_addr] = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    ref_clear();
  endtask

  initial begin
    int order [31];
    vec_t v;
    logic [4:0] a0, a1;

    //            we0 wa0  wd0            we1 wa1  wd1    sb  sba  chk  exp_d         b  cnt
    vt[0] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0,  32'h0,  1'b0, 0};
    vt[1] = '{1'b1, 5'd5, 32'h11,       1'b1, 5'd5, 32'h22, 1'b0, 5'd0, 5'd5,  32'h22, 1'b0, 0};
    vt[2] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 5'd7,  32'h0,  1'b1, 1};
    vt[3] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 5'd7,  32'h77, 1'b1, 1};
    vt[4] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h78, 1'b0, 5'd0, 5'd7,  32'h78, 1'b0, 0};
    vt[5] = '{1'b1, 5'd3, 32'h33,       1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 5'd3,  32'h33, 1'b1, 1};
    vt[6] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 5'd0,  32'h0,  1'b0, 1};
    vt[7] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'h44, 1'b1, 5'd9, 5'd3,  32'h44, 1'b0, 1};
    vt[8] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd12, 32'h5, 1'b0, 5'd0, 5'd12, 32'h5,  1'b0, 1};
    vt[9] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 5'd9,  32'h0,  1'b1, 1};

    // Reset held low: writes and sb_set must be ignored, state is zero without any edge.
    #2 reset = 1'b0;
    #1 check("async_reset_cnt", 32'(pending_cnt), 32'd0);
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF;
    we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h1234;
    sb_set = 1'b1; sb_addr = 5'd6;
    repeat (3) @(posedge clk);
    #1 idle_inputs();
    rd_addr = {5'd6, 5'd4};
    #1;
    check("rst_data0", rd_data[31:0], 32'h0);
    check("rst_data1", rd_data[63:32], 32'h0);
    check("rst_busy", 32'(rd_busy), 32'h0);
    check("rst_cnt", 32'(pending_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      v = vt[i];
      @(negedge clk);
      we0 = v.we0; wa0 = v.wa0; wd0 = v.wd0;
      we1 = v.we1; wa1 = v.wa1; wd1 = v.wd1;
      sb_set = v.sb; sb_addr = v.sba;
      @(posedge clk);
      #1 idle_inputs();
      rd_addr = {v.chk, v.chk};
      #1;
      check($sformatf("vec%0d_data0", i), rd_data[31:0], v.exp_d);
      check($sformatf("vec%0d_data1", i), rd_data[63:32], v.exp_d);
      check($sformatf("vec%0d_busy0", i), 32'(rd_busy[0]), 32'(v.exp_b));
      check($sformatf("vec%0d_cnt", i), 32'(pending_cnt), 32'(v.exp_c));
    end

    // Same-cycle read of a register being written by port 1 while busy.
    @(negedge clk);
    sb_set = 1'b1; sb_addr = 5'd3;
    @(negedge clk);
    idle_inputs();
    we1 = 1'b1; wa1 = 5'd3; wd1 = 32'hABCD;
    rd_addr = {5'd0, 5'd3};
    #1;
`ifdef RF_BYPASS_EN
    check("bypass_data", rd_data[31:0], 32'hABCD);
    check("bypass_busy", 32'(rd_busy[0]), 32'd0);
`else
    check("nobypass_data", rd_data[31:0], 32'h44);
    check("nobypass_busy", 32'(rd_busy[0]), 32'd1);
`endif
    check("bypass_zero_port", rd_data[63:32], 32'h0);
    @(posedge clk);
    #1 idle_inputs();
    #1;
    check("after_bypass_data", rd_data[31:0], 32'hABCD);
    check("after_bypass_busy", 32'(rd_busy[0]), 32'd0);

    // Reset asserted concurrently with the load writeback that would clear busy[9].
    check("pre_midreset_cnt", 32'(pending_cnt), 32'd1);
    @(negedge clk);
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'hDEAD;
    sb_set = 1'b1; sb_addr = 5'd11;
    reset = 1'b0;
    #1 check("midreset_async_cnt", 32'(pending_cnt), 32'd0);
    @(posedge clk);
    #1 rd_addr = {5'd5, 5'd9};
    #1;
    check("midreset_e9", rd_data[31:0], 32'h0);
    check("midreset_e5", rd_data[63:32], 32'h0);
    check("midreset_busy", 32'(rd_busy), 32'h0);
    check("midreset_cnt", 32'(pending_cnt), 32'd0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;

    // Count stress: fill every nonzero register, then drain in shuffled order.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      sb_set = 1'b1; sb_addr = 5'(i);
    end
    @(negedge clk);
    idle_inputs();
    check("stress_full_cnt", 32'(pending_cnt), 32'd31);
    for (int i = 0; i < 31; i++) order[i] = i + 1;
    for (int i = 30; i > 0; i--) begin
      int j, t;
      j = $urandom_range(0, i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 31; i++) begin
      we1 = 1'b1; wa1 = 5'(order[i]); wd1 = $urandom;
      @(negedge clk);
      if (i == 15) check("stress_half_cnt", 32'(pending_cnt), 32'd15);
    end
    idle_inputs();
    #1 check("stress_empty_cnt", 32'(pending_cnt), 32'd0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      we0 = $urandom_range(0, 1); wa0 = 5'($urandom_range(0, 15)); wd0 = $urandom;
      we1 = $urandom_range(0, 1); wa1 = 5'($urandom_range(0, 15)); wd1 = $urandom;
      sb_set = ($urandom_range(0, 2) != 0); sb_addr = 5'($urandom_range(0, 15));
      a0 = 5'($urandom_range(0, 15)); a1 = 5'($urandom_range(0, 31));
      rd_addr = {a1, a0};
      #1;
      check("rnd_data0", rd_data[31:0], exp_read(a0));
      check("rnd_data1", rd_data[63:32], exp_read(a1));
      check("rnd_busy", 32'(rd_busy), 32'({exp_busy(a1), exp_busy(a0)}));
      @(posedge clk);
      ref_step();
      #1 check("rnd_cnt", 32'(pending_cnt), 32'(ref_popcount()));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
